// File: rtl/skid_buffer.sv
// -----------------------------------------------------------------------------
// skid_buffer
//   Two-entry elastic pipeline slice with valid/ready handshakes on both sides.
//   A main register drives the downstream payload directly. A skid register
//   catches the one extra beat that can arrive in the cycle downstream stalls.
//   in_rdy and out_vld are flop outputs, so neither ready nor valid has a
//   combinational path through this block. Throughput is one beat per cycle.
//
// Optional feature (macro SKID_BUFFER_STALL_CNT_EN):
//   Adds a 16-bit saturating counter of cycles with out_vld & !out_rdy.
//
// Parameters:
//   W     payload width in bits
//   INIT  reset value of the main and skid data registers
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_vld     upstream data valid
//   in_data    upstream payload
//   in_rdy     upstream may transfer (flop output)
//   out_vld    downstream data valid (flop output)
//   out_data   downstream payload (main register)
//   out_rdy    downstream accepts
//   stall_cnt  saturating stall counter (only with SKID_BUFFER_STALL_CNT_EN)
// -----------------------------------------------------------------------------
module skid_buffer #(
    parameter int unsigned   W    = 32,
    parameter logic [W-1:0]  INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy
`ifdef SKID_BUFFER_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_rdy_q;
    logic         out_vld_q;

    logic         in_xfer;
    logic         out_xfer;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;

    assign in_xfer  = in_vld & in_rdy_q;
    assign out_xfer = out_vld_q & out_rdy;

    // Next state and register enables
    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nx     = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new beat behind main.
                    state_nx  = FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                // in_rdy is low here, so only the drain case can occur.
                if (out_xfer) begin
                    state_nx       = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // Control registers; handshake outputs are pre-decoded from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state     <= state_nx;
            in_rdy_q  <= (state_nx != FULL);
            out_vld_q <= (state_nx != EMPTY);
        end
    end

    // Data registers, written only on their enables
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= INIT;
            skid_q <= INIT;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_vld  = out_vld_q;
    assign out_data = main_q;

`ifdef SKID_BUFFER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else if (out_vld_q && !out_rdy && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    a_no_x: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({in_vld, out_rdy}));

    a_in_hold: assert property (@(posedge clk) disable iff (rst)
        (in_vld && !in_rdy_q) |=> (!in_vld || $stable(in_data)));

    a_no_full_push: assert property (@(posedge clk) disable iff (rst)
        !((state == FULL) && in_xfer));

endmodule

// File: tb/tb_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer
//   Directed bench for skid_buffer: streaming, fill/drain, reset from FULL,
//   output stability under stall, optional stall counter, and a randomised
//   handshake run checked against an in-order sequence.
// -----------------------------------------------------------------------------
module tb_skid_buffer;

    localparam int unsigned W      = 32;
    localparam int unsigned N_RAND = 2000;

    logic         clk;
    logic         rst;
    logic         in_vld;
    logic [W-1:0] in_data;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic         out_rdy;
`ifdef SKID_BUFFER_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int total;
    int bad;

    skid_buffer #(.W(W), .INIT('0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy)
`ifdef SKID_BUFFER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] snap;
        logic [31:0] send_val;
        logic [31:0] exp_val;
        logic        pending;
        logic        ix;
        logic        ox;
        int          recv;
        int          cyc;

        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;

        // ---------------- reset state
        step();
        step();
        check("rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        check("post_rst_out_vld", {31'd0, out_vld}, 32'd0);

        // ---------------- streaming 0x11, 0x22, 0x33 with out_rdy high
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_data = 32'h11;
        step();
        check("s1_data", out_data, 32'h11);
        check("s1_vld", {31'd0, out_vld}, 32'd1);
        check("s1_rdy", {31'd0, in_rdy}, 32'd1);
        in_data = 32'h22;
        step();
        check("s2_data", out_data, 32'h22);
        check("s2_vld", {31'd0, out_vld}, 32'd1);
        check("s2_rdy", {31'd0, in_rdy}, 32'd1);
        in_data = 32'h33;
        step();
        check("s3_data", out_data, 32'h33);
        check("s3_vld", {31'd0, out_vld}, 32'd1);
        check("s3_rdy", {31'd0, in_rdy}, 32'd1);
        in_vld = 1'b0;
        step();
        check("s_drain_vld", {31'd0, out_vld}, 32'd0);

        // ---------------- fill to FULL then drain
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 32'hA5;
        step();
        check("one_data", out_data, 32'hA5);
        check("one_rdy", {31'd0, in_rdy}, 32'd1);
        in_data = 32'h5A;
        step();
        check("full_rdy", {31'd0, in_rdy}, 32'd0);
        check("full_data", out_data, 32'hA5);
        check("full_vld", {31'd0, out_vld}, 32'd1);
        in_vld = 1'b0;
        step();
        check("full_hold_data", out_data, 32'hA5);
        check("full_hold_rdy", {31'd0, in_rdy}, 32'd0);
        out_rdy = 1'b1;
        step();
        check("pop1_data", out_data, 32'h5A);
        check("pop1_vld", {31'd0, out_vld}, 32'd1);
        check("pop1_rdy", {31'd0, in_rdy}, 32'd1);
        step();
        check("pop2_vld", {31'd0, out_vld}, 32'd0);

        // ---------------- reset from FULL
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 32'h1;
        step();
        in_data = 32'h2;
        step();
        check("pre_rst_rdy", {31'd0, in_rdy}, 32'd0);
        rst     = 1'b1;
        in_data = 32'h99;
        step();
        check("midrst_vld", {31'd0, out_vld}, 32'd0);
        check("midrst_data", out_data, 32'd0);
        check("midrst_rdy", {31'd0, in_rdy}, 32'd0);
        rst    = 1'b0;
        in_vld = 1'b0;
        step();
        check("aftrst_rdy", {31'd0, in_rdy}, 32'd1);
        check("aftrst_vld", {31'd0, out_vld}, 32'd0);
        out_rdy = 1'b1;
        step();
        check("nostale1_vld", {31'd0, out_vld}, 32'd0);
        step();
        check("nostale2_vld", {31'd0, out_vld}, 32'd0);

        // ---------------- stall for three cycles
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 32'hC0FFEE;
        step();
        in_vld = 1'b0;
        snap   = out_data;
        check("stall_first", snap, 32'hC0FFEE);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", out_data, 32'hC0FFEE);
            check("stall_vld", {31'd0, out_vld}, 32'd1);
        end
`ifdef SKID_BUFFER_STALL_CNT_EN
        check("stall_cnt3", {16'd0, stall_cnt}, 32'd3);

        // ---------------- counter saturation
        repeat (70000) @(posedge clk);
        #1;
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        step();
        step();
        check("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
        rst = 1'b1;
        step();
        check("stall_rst", {16'd0, stall_cnt}, 32'd0);
        rst = 1'b0;
        step();
`else
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
`endif

        // ---------------- random handshakes, in-order scoreboard
        send_val = 32'h1000;
        exp_val  = 32'h1000;
        pending  = 1'b0;
        recv     = 0;
        cyc      = 0;
        while (recv < N_RAND && cyc < 20 * N_RAND) begin
            if (!pending) in_vld = 1'($urandom_range(0, 1));
            in_data = send_val;
            out_rdy = 1'($urandom_range(0, 1));
            #1;
            ix = in_vld & in_rdy;
            ox = out_vld & out_rdy;
            if (ox) begin
                check("rand_order", out_data, exp_val);
                exp_val++;
                recv++;
            end
            if (ix) begin
                send_val++;
                pending = 1'b0;
            end else begin
                pending = in_vld;
            end
            step();
            cyc++;
        end
        check("rand_count", recv, N_RAND);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        step();
        step();
        check("rand_tail_vld", {31'd0, out_vld}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
